// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and sync-window helper shared by the timing generator.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE = 1'b0;

  // Sync level for a scan position, active inside [start, start+len).
  function automatic logic sync_level(input int unsigned pos, input int unsigned start,
                                      input int unsigned len);
    return (pos >= start && pos < start + len) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate enable: one-cycle registered p_tick every CLK_DIV sys_clk cycles.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic p_tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] r_div_cnt;
  logic            r_p_tick;
  logic            w_wrap;

  assign w_wrap = (r_div_cnt == DivW'(CLK_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div_cnt <= '0;
      r_p_tick  <= 1'b0;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + DivW'(1);
      r_p_tick  <= w_wrap;
    end
  end

  assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 scan counters, registered timing outputs and sync delay line.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = 10,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SYNC_DELAY   = 1,
  parameter int unsigned FRAME_CNT_W  = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  output logic                    p_tick,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  output logic                    video_on,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    frame_start,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
);

  localparam int unsigned Sw = SCREEN_WIDTH;

  logic          w_p_tick;
  logic [Sw-1:0] r_x, r_y;
  logic [Sw-1:0] w_x_nxt, w_y_nxt;
  logic          r_video_on, r_hs_raw, r_vs_raw, r_frame_start;
  logic          w_frame_start_nxt;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .p_tick    (w_p_tick)
  );

  always_comb begin
    w_x_nxt = r_x + Sw'(1);
    w_y_nxt = r_y;
    if (r_x == Sw'(H_TOTAL - 1)) begin
      w_x_nxt = '0;
      w_y_nxt = (r_y == Sw'(V_TOTAL - 1)) ? '0 : r_y + Sw'(1);
    end
  end

  assign w_frame_start_nxt = w_p_tick && (w_x_nxt == '0) && (w_y_nxt == '0);

  // Outputs derive from the next counter values so they change together with x/y.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_x           <= Sw'(H_TOTAL - 1);
      r_y           <= Sw'(V_TOTAL - 1);
      r_video_on    <= 1'b0;
      r_hs_raw      <= ~SYNC_ACTIVE;
      r_vs_raw      <= ~SYNC_ACTIVE;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start_nxt;
      if (w_p_tick) begin
        r_x        <= w_x_nxt;
        r_y        <= w_y_nxt;
        r_video_on <= (w_x_nxt < Sw'(H_VISIBLE)) && (w_y_nxt < Sw'(V_VISIBLE));
        r_hs_raw   <= sync_level(32'(w_x_nxt), H_VISIBLE + H_FP, H_SYNC);
        r_vs_raw   <= sync_level(32'(w_y_nxt), V_VISIBLE + V_FP, V_SYNC);
      end
    end
  end

  if (SYNC_DELAY == 0) begin : g_no_dly
    assign hsync = r_hs_raw;
    assign vsync = r_vs_raw;
  end else begin : g_dly
    logic [SYNC_DELAY-1:0] r_hs_pipe, r_vs_pipe;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_hs_pipe <= {SYNC_DELAY{~SYNC_ACTIVE}};
        r_vs_pipe <= {SYNC_DELAY{~SYNC_ACTIVE}};
      end else if (w_p_tick) begin
        r_hs_pipe[0] <= r_hs_raw;
        r_vs_pipe[0] <= r_vs_raw;
        for (int i = 1; i < int'(SYNC_DELAY); i++) begin
          r_hs_pipe[i] <= r_hs_pipe[i-1];
          r_vs_pipe[i] <= r_vs_pipe[i-1];
        end
      end
    end

    assign hsync = r_hs_pipe[SYNC_DELAY-1];
    assign vsync = r_vs_pipe[SYNC_DELAY-1];
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_start_nxt) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

  assign p_tick      = w_p_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;

endmodule
